// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage hazard unit built around a shifting write
// scoreboard. It tracks the destination register of every instruction in the
// DEPTH post-decode stages (stage 1 = E ... DEPTH = W). From that it produces
// forward selects for both decode sources, load/multi-cycle-use stalls,
// per-stage stall/flush vectors, and a sequenced exception flush. The flush is
// deferred while a unit-wide long stall is in progress.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   long_stall         unit-wide stall (icache, dcache, divider)
//   issue_D            valid instruction in D
//   rs_D, rt_D         source registers; use_a_D/use_b_D say whether each is read
//   dst_D              destination register (0 = no write)
//   rdy_stage_D        first stage whose result bus carries the value
//   redirect_D         taken branch/jump resolved in D
//   except_M           exception detected in stage 2
//   fwd_a_D, fwd_b_D   0 = regfile, k = stage-k result bus
//   stall, flush       bit0 F, bit1 D, bit k+1 stage k
//   fsm_busy           exception sequence in progress
//
// Optional build macro HAZARD_PERF_CNT_EN adds three 32-bit wrapping counters:
//   hz_cnt (hazard-stall cycles), ls_cnt (long_stall cycles),
//   ex_cnt (entries into the flush state).

// One scoreboard entry compared against one decode source.
module hsb_entry_cmp #(
  parameter int REG_W = 5
) (
  input  logic             en,
  input  logic             valid,
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] src,
  output logic             hit
);
  assign hit = en & valid & (dst == src);
endmodule

module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int REG_W = 5,
  parameter int SELW  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             long_stall,
  input  logic             issue_D,
  input  logic [REG_W-1:0] rs_D,
  input  logic [REG_W-1:0] rt_D,
  input  logic             use_a_D,
  input  logic             use_b_D,
  input  logic [REG_W-1:0] dst_D,
  input  logic [SELW-1:0]  rdy_stage_D,
  input  logic             redirect_D,
  input  logic             except_M,
  output logic [SELW-1:0]  fwd_a_D,
  output logic [SELW-1:0]  fwd_b_D,
  output logic [DEPTH+1:0] stall,
  output logic [DEPTH+1:0] flush,
  output logic             fsm_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      hz_cnt,
  output logic [31:0]      ls_cnt,
  output logic [31:0]      ex_cnt
`endif
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic [SELW-1:0]  rdy;
  } sb_ent_t;

  typedef enum logic [1:0] {RUN = 2'd0, PEND = 2'd1, FLUSH = 2'd2} state_t;

  sb_ent_t [DEPTH:1] sb, sb_nxt;
  state_t            state, state_nxt;

  // Source 0 = rs (a), source 1 = rt (b).
  logic [1:0][REG_W-1:0] src;
  logic [1:0]            src_en;
  logic [1:0][DEPTH:1]   hit;
  logic [1:0][SELW-1:0]  fwd;
  logic [1:0]            haz;
  logic                  hazard;

  assign src[0]    = rs_D;
  assign src[1]    = rt_D;
  assign src_en[0] = use_a_D & (rs_D != '0);
  assign src_en[1] = use_b_D & (rt_D != '0);

  for (genvar s = 0; s < 2; s++) begin : g_src
    for (genvar k = 1; k <= DEPTH; k++) begin : g_ent
      hsb_entry_cmp #(.REG_W(REG_W)) u_cmp (
        .en    (src_en[s]),
        .valid (sb[k].v),
        .dst   (sb[k].dst),
        .src   (src[s]),
        .hit   (hit[s][k])
      );
    end

    // The youngest (lowest-index) matching writer wins. If its result is not
    // on a bus yet, the instruction in D has to wait.
    always_comb begin
      logic done;
      done   = 1'b0;
      fwd[s] = '0;
      haz[s] = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (!done && hit[s][k]) begin
          done = 1'b1;
          if (SELW'(k) >= sb[k].rdy) fwd[s] = SELW'(k);
          else                       haz[s] = 1'b1;
        end
      end
    end
  end

  assign fwd_a_D = fwd[0];
  assign fwd_b_D = fwd[1];
  assign hazard  = issue_D & (|haz);

  // Stall/flush priority: long stall, exception flush, data hazard, redirect.
  always_comb begin
    stall = '0;
    flush = '0;
    if (long_stall) begin
      stall = '1;
    end else if (state == FLUSH) begin
      flush[3:0] = 4'hF;
    end else if (hazard) begin
      stall[1:0] = 2'b11;
      flush[2]   = 1'b1;
    end else if (redirect_D) begin
      flush[0] = 1'b1;
    end
  end

  // Scoreboard advance. During the exception flush, the instructions in
  // stages 1..2 are squashed. So they move down the pipe as bubbles, while
  // the older stages still commit.
  always_comb begin
    sb_nxt = sb;
    if (!long_stall) begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_nxt[k] = sb[k-1];
        if (state == FLUSH && k <= 3) sb_nxt[k].v = 1'b0;
      end
      sb_nxt[1].v   = issue_D & (dst_D != '0) & ~stall[1] & ~flush[1];
      sb_nxt[1].dst = dst_D;
      sb_nxt[1].rdy = rdy_stage_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else     sb <= sb_nxt;
  end

  // Exception sequencer. While a long stall is active, the only move allowed
  // is RUN->PEND. This way the flush never races a frozen pipe.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (except_M) state_nxt = long_stall ? PEND : FLUSH;
      PEND:    if (!long_stall) state_nxt = FLUSH;
      FLUSH:   if (!long_stall) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      fsm_busy <= 1'b0;
    end else begin
      state    <= state_nxt;
      fsm_busy <= (state_nxt != RUN);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hz_cnt <= '0;
      ls_cnt <= '0;
      ex_cnt <= '0;
    end else begin
      if (!long_stall && state != FLUSH && hazard) hz_cnt <= hz_cnt + 32'd1;
      if (long_stall)                              ls_cnt <= ls_cnt + 32'd1;
      if (state != FLUSH && state_nxt == FLUSH)    ex_cnt <= ex_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipeline hazard unit. Replaces fixed E/M/W compare logic with a shifting write scoreboard over DEPTH post-decode stages.
- Produces decode-stage forward selects, load/multi-cycle-use stalls, per-stage stall/flush vectors, and a sequenced exception-flush FSM that defers flushes during long stalls.
- Sits beside the datapath; the decode stage reads all operands (branch/jr included) through its selects.

Parameters:
- DEPTH, 3, post-decode stages tracked (stage 1=E … DEPTH=W).
- REG_W, 5, register index width.
- SELW, $clog2(DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- long_stall  in  1  any unit-wide stall (icache, dcache, divider)
- issue_D  in  1  valid instruction in D
- rs_D, rt_D  in  REG_W  source registers
- use_a_D, use_b_D  in  1  source actually read in D
- dst_D  in  REG_W  destination (0 = no write)
- rdy_stage_D  in  SELW  first stage whose output carries the result (ALU 1, load 2, mfc0 2)
- redirect_D  in  1  taken branch/jump resolved in D
- except_M  in  1  exception detected in stage 2
- fwd_a_D, fwd_b_D  out  SELW  0 = regfile, k = stage-k result bus
- stall  out  DEPTH+2  bit0 F, bit1 D, bit k+1 stage k
- flush  out  DEPTH+2  same bit order
- fsm_busy  out  1  exception sequence in progress

Behaviour:
- Scoreboard: DEPTH entries {valid, dst, rdy}; entry k describes the instruction in stage k. Reset: all invalid, FSM RUN, all outputs 0.
- Shift on every cycle without long_stall: entry k→k+1, entry DEPTH retires; entry 1 loads {issue_D & dst_D!=0 & ~stall[1] & ~flush[1], dst_D, rdy_stage_D}, else invalid (bubble).
- Match per source (skipped if use=0 or reg=0): the lowest-index valid entry with equal dst wins.
- Forward/stall: winner at stage k with k≥rdy gives fwd=k; k<rdy gives a hazard and fwd=0. No match gives fwd=0. Combinational from the current scoreboard.
- hazard = issue_D & (hazard_a | hazard_b).
- Priority 1, long_stall: stall = all ones, flush = 0, scoreboard frozen, FSM only moves RUN→PEND.
- Priority 2, FLUSH state: flush bits 0..3 = 1 (F, D, stage 1, stage 2). Stage ≥3 commits normally. stall = 0. Entries 1..2 are invalidated before the shift, so entry 1 loads invalid.
- Priority 3, hazard: stall bits 0,1 = 1; flush bit 2 = 1 (bubble into E).
- Priority 4, redirect_D with no hazard: flush bit 0 = 1.
- Otherwise all 0.
- FSM, 2-bit state:
  - RUN: except_M & ~long_stall → FLUSH. except_M & long_stall → PEND.
  - PEND: hold until ~long_stall → FLUSH. Further except_M is ignored.
  - FLUSH: one cycle → RUN.
  - fsm_busy = state≠RUN.
- In PEND, except_M need not remain high.
- Asynchronous reset mid-sequence returns to RUN and clears the scoreboard immediately.
- Latency: forward/stall decisions in the same cycle; the flush appears the cycle after except_M (or after long_stall drops).

Optional Feature:
- HAZARD_PERF_CNT_EN defined: adds outputs hz_cnt, ls_cnt, ex_cnt (32-bit each).
  - hz_cnt counts hazard-stall cycles, ls_cnt counts long_stall cycles, ex_cnt counts FLUSH entries.
  - All three reset to 0 and wrap at 2^32.
- Undefined: counter ports and logic are absent; all other behaviour is identical.

Test Plan:
- ALU chain: add r3 issued, then sub uses rs=r3 next cycle (entry1 dst=3, rdy=1) → fwd_a_D=1, stall=0. One cycle later → fwd_a_D=2.
- Load-use: lw r5 (rdy=2) then use rt=r5 → cycle0 stall=0b00011, flush=0b00100. Cycle1: lw at stage 2 → fwd_b_D=2, no stall.
- Youngest wins: r7 written by stage 3 and stage 1 (rdy=1) → fwd_a_D=1. Source r0 → fwd=0, never stalls.
- Exception: except_M=1 with long_stall=0 → next cycle flush=0b01111, fsm_busy=1. Entries 1..2 invalid. Following cycle: state RUN.
- Deferred exception: except_M with long_stall=1 for 4 cycles → stall all ones and flush 0 throughout. FLUSH occurs the cycle after long_stall falls. Reset asserted in PEND → RUN, outputs 0.
- Redirect with hazard: redirect_D=1 and load-use hazard → flush=0b00100 only. Next cycle, hazard cleared → flush=0b00001.
